paddle_input_ctrl: RTL and testbench
====================================

Name: paddle_input_ctrl

Overview:
- Sequences the left/right move commands consumed by the paddle position logic once per frame.
- Synchronises and debounces the raw player buttons.
- Arbitrates paddle control between the player and an attract-mode autopilot that tracks the ball after a period of player inactivity.
- Sits between the board button pins / ball logic and the paddle position register.

Parameters:
DEBOUNCE_FRAMES, 3, consecutive frame_pulse samples a changed button level must hold before the debounced level follows (1..15)
IDLE_FRAMES, 600, frames with no debounced press before entering attract mode (about 10 s at 60 Hz; 2..1023)
DEADBAND, 4, autopilot dead zone in pixels around paddle_x where no move is commanded

Ports:
clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
frame_pulse  input  1  one-clk pulse per frame, same pulse the paddle logic uses
btn_left_raw  input  1  asynchronous left button, active high
btn_right_raw  input  1  asynchronous right button, active high
ball_x  input  10  current ball centre x (pixels)
paddle_x  input  10  current paddle centre x from the paddle logic
demo_enable  input  1  permits attract mode
button_left  output  1  move-left command to the paddle logic
button_right  output  1  move-right command to the paddle logic
attract_mode  output  1  high while the autopilot owns the paddle

Behaviour:
- Reset, on the clk edge with Rst high, regardless of any operation in progress:
  - Synchroniser flops, debounced levels, debounce counters and idle counter go to 0.
  - FSM goes to PLAY.
  - button_left, button_right and attract_mode go to 0.
- Synchroniser: two flops per raw button, clocked every clk. Only synchronised levels are used downstream.
- Debounce, per button, evaluated only on clk edges with frame_pulse=1:
  - Synchronised level equal to debounced level: counter cleared.
  - Otherwise the counter increments.
  - When the counter would reach DEBOUNCE_FRAMES, the debounced level takes the synchronised level and the counter clears.
  - A bounce back before then clears the counter with no change.
- Player command: pl_left = dL & ~dR; pl_right = dR & ~dL.
  - Both debounced high gives no move; the right button is not given priority.
- Autopilot, using 11-bit unsigned arithmetic so that no wrap occurs:
  - ap_right when ball_x > paddle_x + DEADBAND.
  - ap_left when ball_x + DEADBAND < paddle_x.
  - Otherwise neither.
  - Never both.
- Idle counter, 10 bits, updated only on frame_pulse:
  - Cleared whenever dL|dR is high, after that frame's debounce update.
  - Otherwise increments, saturating at IDLE_FRAMES-1.
- FSM, evaluated on frame_pulse edges except the demo_enable exit:
  - PLAY -> ATTRACT when the idle counter equals IDLE_FRAMES-1, demo_enable=1 and no debounced press.
  - With demo_enable=0 the counter saturates and the FSM stays in PLAY.
  - ATTRACT -> PLAY on the frame_pulse where dL|dR becomes 1; the idle counter clears.
  - ATTRACT -> PLAY on any clk where demo_enable=0, without waiting for frame_pulse.
- Outputs:
  - button_left, button_right and attract_mode are registered.
  - They update only on clk edges with frame_pulse=1 (attract_mode also updates on the demo_enable exit).
  - They take the next-state source: player command in PLAY, autopilot command in ATTRACT.
  - They hold stable between pulses, so the paddle logic sees them at the following frame_pulse: exactly one frame of latency.
  - On the demo_enable exit, button_left and button_right clear to 0 on that same clk.
- Simultaneous events:
  - A press on the same frame the idle counter would trigger ATTRACT: press wins, the FSM stays in PLAY and the counter clears.
  - frame_pulse coinciding with Rst: reset wins.
- No combinational path from any input to any output.

Test Plan:
- Reset and hold: hold Rst 3 clks with btn_left_raw=1 -> all outputs 0. Release Rst, keep btn_left_raw=1 -> button_left=1 after the 3rd frame_pulse sample plus the output update, i.e. from the 3rd frame_pulse edge.
- Bounce rejection: btn_right_raw high for 2 frames, low 1 frame, high 3 frames -> button_right rises only after the final 3 consecutive high samples. Both buttons held -> button_left=button_right=0.
- Idle entry: IDLE_FRAMES=8, demo_enable=1, no presses -> attract_mode rises on the 8th frame_pulse. With demo_enable=0, run 20 frames -> attract_mode stays 0.
- Autopilot tracking in ATTRACT:
  - paddle_x=320, ball_x=330 -> button_right=1.
  - ball_x=322 -> both 0.
  - ball_x=2, paddle_x=8 -> button_left=1, with no underflow.
  - ball_x=1023, paddle_x=1020 -> both 0.
- Exit: in ATTRACT, debounced left press -> attract_mode=0 and button_left=1 on that frame_pulse. In ATTRACT, drop demo_enable mid-frame -> attract_mode and both buttons 0 the next clk.
- Collision and mid-operation reset:
  - Press debounces on the same frame the idle count expires -> stays PLAY, idle counter 0.
  - Assert Rst while in ATTRACT with button_right=1 -> PLAY, all outputs 0 next clk.

Source files
------------

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: debounced player / attract-mode autopilot arbitration of paddle move commands
module paddle_input_ctrl #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int IDLE_FRAMES = 600,
  parameter int DEADBAND = 4
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       frame_pulse,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  input  logic [9:0] ball_x,
  input  logic [9:0] paddle_x,
  input  logic       demo_enable,
  output logic       button_left,
  output logic       button_right,
  output logic       attract_mode
);
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [9:0] IDLE_MAX = 10'(IDLE_FRAMES - 1);
  localparam logic [10:0] DZ = 11'(DEADBAND);
  typedef enum logic {PLAY, ATTRACT} state_t;
  state_t state, state_n;
  logic [1:0] sync_l, sync_r;
  logic deb_l, deb_r, deb_l_n, deb_r_n;
  logic [3:0] cnt_l, cnt_r, cnt_l_n, cnt_r_n;
  logic [9:0] idle, idle_n;
  logic [10:0] bx, px;
  logic press, ap_l, ap_r, pl_l, pl_r, bl_n, br_n, demo_exit;
  always_comb begin
    cnt_l_n = (sync_l[1] == deb_l || cnt_l == DB_MAX) ? 4'd0 : cnt_l + 4'd1;
    cnt_r_n = (sync_r[1] == deb_r || cnt_r == DB_MAX) ? 4'd0 : cnt_r + 4'd1;
    deb_l_n = (sync_l[1] != deb_l && cnt_l == DB_MAX) ? sync_l[1] : deb_l;
    deb_r_n = (sync_r[1] != deb_r && cnt_r == DB_MAX) ? sync_r[1] : deb_r;
    press = deb_l_n | deb_r_n;
    idle_n = press ? 10'd0 : (idle == IDLE_MAX ? idle : idle + 10'd1);
    pl_l = deb_l_n & ~deb_r_n;
    pl_r = deb_r_n & ~deb_l_n;
    bx = {1'b0, ball_x};
    px = {1'b0, paddle_x};
    ap_r = bx > px + DZ;
    ap_l = bx + DZ < px;
    demo_exit = (state == ATTRACT) && !demo_enable;
    state_n = (state == ATTRACT)
      ? ((demo_exit || (frame_pulse && press)) ? PLAY : ATTRACT)
      : ((frame_pulse && demo_enable && !press && idle == IDLE_MAX) ? ATTRACT : PLAY);
    bl_n = (state_n == ATTRACT) ? ap_l : pl_l;
    br_n = (state_n == ATTRACT) ? ap_r : pl_r;
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      sync_l <= '0;
      sync_r <= '0;
      deb_l <= 1'b0;
      deb_r <= 1'b0;
      cnt_l <= '0;
      cnt_r <= '0;
      idle <= '0;
      state <= PLAY;
      button_left <= 1'b0;
      button_right <= 1'b0;
    end else begin
      sync_l <= {sync_l[0], btn_left_raw};
      sync_r <= {sync_r[0], btn_right_raw};
      state <= state_n;
      if (frame_pulse) begin
        deb_l <= deb_l_n;
        deb_r <= deb_r_n;
        cnt_l <= cnt_l_n;
        cnt_r <= cnt_r_n;
        idle <= idle_n;
      end
      if (demo_exit) begin
        button_left <= 1'b0;
        button_right <= 1'b0;
      end else if (frame_pulse) begin
        button_left <= bl_n;
        button_right <= br_n;
      end
    end
  end
  assign attract_mode = (state == ATTRACT);
endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed vectors, hand sequences and randomized run against a frame-level model
module tb_paddle_input_ctrl;
  localparam int DBF = 3, IDLE = 8, DZ = 4;
  logic clk = 0, Rst = 1, frame_pulse = 0, btn_left_raw = 0, btn_right_raw = 0, demo_enable = 0;
  logic [9:0] ball_x = 0, paddle_x = 0;
  logic button_left, button_right, attract_mode;
  int checks = 0, errors = 0;
  bit m_att, m_dl, m_dr, m_bl, m_br;
  int m_idle;
  bit ql[$], qr[$], hl[$], hr[$];
  typedef struct {logic [9:0] bx, px; logic el, er;} vec_t;
  vec_t v[10];
  always #5 clk = ~clk;
  paddle_input_ctrl #(.DEBOUNCE_FRAMES(DBF), .IDLE_FRAMES(IDLE), .DEADBAND(DZ)) dut (
    .clk(clk), .Rst(Rst), .frame_pulse(frame_pulse), .btn_left_raw(btn_left_raw),
    .btn_right_raw(btn_right_raw), .ball_x(ball_x), .paddle_x(paddle_x), .demo_enable(demo_enable),
    .button_left(button_left), .button_right(button_right), .attract_mode(attract_mode)
  );
  function automatic bit run_differs(input bit h[$], input bit d);
    if (h.size() < DBF) return 0;
    for (int i = h.size() - DBF; i < h.size(); i++) if (h[i] == d) return 0;
    return 1;
  endfunction
  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    bit sl, sr, press, trig, att0;
    if (Rst) begin
      m_att = 0; m_dl = 0; m_dr = 0; m_bl = 0; m_br = 0; m_idle = 0;
      ql = {1'b0, 1'b0}; qr = {1'b0, 1'b0}; hl.delete(); hr.delete();
    end else begin
      sl = ql.pop_front(); ql.push_back(btn_left_raw);
      sr = qr.pop_front(); qr.push_back(btn_right_raw);
      att0 = m_att;
      if (frame_pulse) begin
        hl.push_back(sl); hr.push_back(sr);
        if (hl.size() > DBF) void'(hl.pop_front());
        if (hr.size() > DBF) void'(hr.pop_front());
        if (run_differs(hl, m_dl)) begin m_dl = !m_dl; hl.delete(); end
        if (run_differs(hr, m_dr)) begin m_dr = !m_dr; hr.delete(); end
        press = m_dl | m_dr;
        trig = !m_att && demo_enable && !press && m_idle == IDLE - 1;
        m_idle = press ? 0 : (m_idle < IDLE - 1 ? m_idle + 1 : m_idle);
        if (m_att && press) m_att = 0;
        else if (trig) m_att = 1;
        if (m_att) begin
          m_br = int'(ball_x) > int'(paddle_x) + DZ;
          m_bl = int'(ball_x) + DZ < int'(paddle_x);
        end else begin
          m_bl = m_dl && !m_dr;
          m_br = m_dr && !m_dl;
        end
      end
      if (att0 && !demo_enable) begin m_att = 0; m_bl = 0; m_br = 0; end
    end
  endtask
  task automatic tick(input bit fp);
    frame_pulse = fp;
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {attract_mode, button_left, button_right}, {m_att, m_bl, m_br});
  endtask
  task automatic frames(input int n);
    repeat (n) begin
      repeat (3) tick(0);
      tick(1);
    end
  endtask
  task automatic do_reset();
    Rst = 1; tick(1); Rst = 0;
  endtask
  initial begin
    v[0] = '{330, 320, 0, 1}; v[1] = '{322, 320, 0, 0}; v[2] = '{2, 8, 1, 0};
    v[3] = '{1023, 1020, 0, 0}; v[4] = '{324, 320, 0, 0}; v[5] = '{325, 320, 0, 1};
    v[6] = '{316, 320, 0, 0}; v[7] = '{315, 320, 1, 0}; v[8] = '{0, 1023, 1, 0};
    v[9] = '{1023, 0, 0, 1};
    btn_left_raw = 1;
    repeat (3) tick(1);
    chk("reset_hold", {attract_mode, button_left, button_right}, 3'b000);
    Rst = 0;
    frames(2);
    chk("deb_left_early", {2'b0, button_left}, 3'b000);
    frames(1);
    chk("deb_left_rise", {attract_mode, button_left, button_right}, 3'b010);
    btn_left_raw = 0;
    frames(3);
    chk("deb_left_fall", {attract_mode, button_left, button_right}, 3'b000);
    btn_right_raw = 1; frames(2);
    btn_right_raw = 0; frames(1);
    btn_right_raw = 1; frames(2);
    chk("bounce_reject", {2'b0, button_right}, 3'b000);
    frames(1);
    chk("bounce_accept", {attract_mode, button_left, button_right}, 3'b001);
    btn_left_raw = 1; frames(3);
    chk("both_held", {attract_mode, button_left, button_right}, 3'b000);
    btn_left_raw = 0; btn_right_raw = 0;
    do_reset();
    frames(20);
    chk("no_demo_no_attract", {2'b0, attract_mode}, 3'b000);
    demo_enable = 1;
    do_reset();
    frames(7);
    chk("idle_before", {2'b0, attract_mode}, 3'b000);
    frames(1);
    chk("idle_entry", {attract_mode, button_left, button_right}, 3'b100);
    for (int i = 0; i < 10; i++) begin
      ball_x = v[i].bx; paddle_x = v[i].px;
      frames(1);
      chk($sformatf("autopilot_%0d", i), {attract_mode, button_left, button_right}, {1'b1, v[i].el, v[i].er});
    end
    btn_left_raw = 1; frames(2);
    chk("exit_press_early", {2'b0, attract_mode}, 3'b001);
    frames(1);
    chk("exit_press", {attract_mode, button_left, button_right}, 3'b010);
    btn_left_raw = 0; ball_x = 330; paddle_x = 320;
    frames(12);
    chk("reenter", {attract_mode, button_left, button_right}, 3'b101);
    tick(0); demo_enable = 0; tick(0);
    chk("demo_exit", {attract_mode, button_left, button_right}, 3'b000);
    demo_enable = 1;
    frames(12);
    chk("reenter2", {attract_mode, button_left, button_right}, 3'b101);
    tick(0); Rst = 1; tick(0);
    chk("reset_in_attract", {attract_mode, button_left, button_right}, 3'b000);
    Rst = 0;
    frames(5);
    btn_left_raw = 1; frames(2);
    chk("collision_pre", {attract_mode, button_left, button_right}, 3'b000);
    frames(1);
    chk("collision", {attract_mode, button_left, button_right}, 3'b010);
    btn_left_raw = 0; frames(4);
    chk("collision_idle_clear", {2'b0, attract_mode}, 3'b000);
    for (int i = 0; i < 6000; i++) begin
      int b;
      if ($urandom_range(0, 15) == 0) btn_left_raw = ~btn_left_raw;
      if ($urandom_range(0, 15) == 0) btn_right_raw = ~btn_right_raw;
      if ($urandom_range(0, 199) == 0) demo_enable = ~demo_enable;
      if ($urandom_range(0, 299) == 0) begin btn_left_raw = 0; btn_right_raw = 0; end
      paddle_x = 10'($urandom_range(0, 1023));
      b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1023)) : int'(paddle_x) + int'($urandom_range(0, 16)) - 8;
      ball_x = 10'(b < 0 ? 0 : (b > 1023 ? 1023 : b));
      Rst = ($urandom_range(0, 599) == 0);
      tick($urandom_range(0, 2) == 0);
    end
    Rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
